// File: rtl/uart_rx.sv
// uart_rx: oversampling asynchronous serial receiver (start, DATA_WIDTH data
// bits LSB first, optional even parity, one stop bit). Each bit is sampled at
// its mid-point, counted from the synchronized falling edge of the start bit.
// Optional feature: define UART_RX_PARITY_EN to expect an even-parity bit
// between the data bits and the stop bit.
module uart_rx #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  busy,
  output logic                  frame_err,
  output logic                  parity_err
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam int BIT_W        = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t                state, state_nxt;
  logic                  rx_meta, rx_s, rx_prev;
  logic [CNT_W-1:0]      cnt;
  logic [BIT_W-1:0]      bit_cnt;
  logic [DATA_WIDTH-1:0] shift;
  logic                  bit_done;
  logic                  ok_stb, ferr_stb, perr_stb;
`ifdef UART_RX_PARITY_EN
  logic                  par_bit;
`endif

  // Two-flop synchronizer plus one history flop for falling-edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

  assign bit_done = (cnt == LAST_CNT);

  // Next-state logic and single-cycle resolution strobes
  always_comb begin
    state_nxt = state;
    ok_stb    = 1'b0;
    ferr_stb  = 1'b0;
    perr_stb  = 1'b0;
    case (state)
      IDLE: begin
        // Only a 1->0 transition starts a frame, so a stuck-low line is inert
        if (rx_prev && !rx_s) state_nxt = START;
      end
      START: begin
        // Line back high at mid start bit: a glitch, drop it silently
        if (cnt == HALF_CNT) state_nxt = rx_s ? IDLE : DATA;
      end
      DATA: begin
`ifdef UART_RX_PARITY_EN
        if (bit_done && bit_cnt == LAST_BIT) state_nxt = PARITY;
`else
        if (bit_done && bit_cnt == LAST_BIT) state_nxt = STOP;
`endif
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (bit_done) state_nxt = STOP;
      end
`endif
      STOP: begin
        if (bit_done) begin
          state_nxt = IDLE;
          // Framing error outranks parity error, which outranks a good word
          if (!rx_s) begin
            ferr_stb = 1'b1;
`ifdef UART_RX_PARITY_EN
          end else if ((^shift) != par_bit) begin
            perr_stb = 1'b1;
`endif
          end else begin
            ok_stb = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register, baud/bit counters and the data shift register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_cnt <= '0;
      shift   <= '0;
`ifdef UART_RX_PARITY_EN
      par_bit <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      if (state_nxt != state || state == IDLE || bit_done) cnt <= '0;
      else                                                  cnt <= cnt + CNT_W'(1);
      if (state != DATA)  bit_cnt <= '0;
      else if (bit_done)  bit_cnt <= bit_cnt + BIT_W'(1);
      // Right shift: the first (LSB) bit ends up in bit 0 after the last shift
      if (state == DATA && bit_done) shift <= {rx_s, shift[DATA_WIDTH-1:1]};
`ifdef UART_RX_PARITY_EN
      if (state == PARITY && bit_done) par_bit <= rx_s;
`endif
    end
  end

  // Registered outputs; busy falls on the same edge as the final strobe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out   <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      data_valid <= ok_stb;
      frame_err  <= ferr_stb;
      busy       <= (state_nxt != IDLE);
      if (ok_stb) data_out <= shift;
    end
  end

`ifdef UART_RX_PARITY_EN
  // Parity error strobe, registered alongside the other strobes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) parity_err <= 1'b0;
    else     parity_err <= perr_stb;
  end
`else
  assign parity_err = 1'b0;
  logic unused_perr;
  assign unused_perr = perr_stb;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed bench for uart_rx. Frames are serialized in the bench;
// each frame's expected outcome (good word, framing or parity error) and its
// start cycle are queued, and a per-cycle compare process checks strobes,
// strobe latency, exclusivity and the held data_out value against that model.
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int CLK_FREQ = 100_000_000;
  localparam int BAUD     = 10_000_000;
  localparam int DW       = 8;
  localparam int CPB      = CLK_FREQ / BAUD;
  localparam int BIT_NS   = CPB * 10;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN  = 1'b1;
  localparam int NOM_LAT = 2 + CPB / 2 + (DW + 2) * CPB;
`else
  localparam bit PAR_EN  = 1'b0;
  localparam int NOM_LAT = 2 + CPB / 2 + (DW + 1) * CPB;
`endif
  localparam int K_OK = 0, K_FERR = 1, K_PERR = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rx  = 1'b1;
  logic [DW-1:0] data_out;
  logic          data_valid, busy, frame_err, parity_err;

  uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .rx(rx), .data_out(data_out),
    .data_valid(data_valid), .busy(busy), .frame_err(frame_err),
    .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            kind;
    logic [DW-1:0] data;
    int            t0;
  } ev_t;

  ev_t           exp_q[$];
  ev_t           ev;
  int            n_vec = 0, n_err = 0;
  int            cyc = 0;
  int            strobes, kind_act, lat;
  int            busy_run = 0, busy_len = 0;
  logic [DW-1:0] model_dout = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_vec++;
    if (act < lo || act > hi) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  always @(posedge clk) cyc++;

  // Track the length of the most recent busy-high run
  always @(negedge clk) begin
    if (busy) busy_run++;
    else if (busy_run != 0) begin
      busy_len = busy_run;
      busy_run = 0;
    end
  end

  // Per-cycle compare against the frame-level model
  always @(negedge clk) begin
    if (rst) begin
      model_dout = '0;
    end else begin
      strobes = int'(data_valid) + int'(frame_err) + int'(parity_err);
      if (strobes > 1) check("strobe_exclusive", strobes, 1);
      if (strobes != 0) begin
        check("busy_low_at_strobe", busy, 0);
        if (exp_q.size() == 0) begin
          check("unexpected_strobe", {data_valid, frame_err, parity_err}, 0);
        end else begin
          ev = exp_q.pop_front();
          kind_act = data_valid ? K_OK : (frame_err ? K_FERR : K_PERR);
          check("strobe_kind", kind_act, ev.kind);
          lat = cyc - ev.t0;
          check_range("strobe_latency", lat, NOM_LAT - 2, NOM_LAT + 2);
          if (ev.kind == K_OK) model_dout = ev.data;
        end
      end
      check("data_out", data_out, model_dout);
    end
  end

  // Serialize one frame; the outcome is queued before the start bit goes out
  task automatic send(input logic [DW-1:0] d, input logic stop_b, input logic par_b,
                      input int bit_ns);
    ev_t e;
    e.kind = (stop_b == 1'b0) ? K_FERR : ((PAR_EN && (par_b != ^d)) ? K_PERR : K_OK);
    e.data = d;
    e.t0   = cyc;
    exp_q.push_back(e);
    rx = 1'b0;
    #(bit_ns);
    for (int i = 0; i < DW; i++) begin
      rx = d[i];
      #(bit_ns);
    end
    if (PAR_EN) begin
      rx = par_b;
      #(bit_ns);
    end
    rx = stop_b;
    #(bit_ns);
  endtask

  task automatic send_ok(input logic [DW-1:0] d);
    send(d, 1'b1, ^d, BIT_NS);
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d strobes outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
    repeat (5) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    repeat (3) @(negedge clk);
    check("rst_data_out", data_out, 0);
    check("rst_data_valid", data_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_parity_err", parity_err, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Single frame
    send_ok(8'hA5);
    drain(200);
    check("a5_data_out", data_out, 8'hA5);
    check_range("a5_busy_len", busy_len, 93, 97);

    // Back-to-back frames
    send_ok(8'hA5);
    send_ok(8'h3C);
    drain(200);
    check("b2b_data_out", data_out, 8'h3C);

    // 3-cycle low glitch
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    check_range("glitch_busy_len", busy_len, 3, 8);
    check("glitch_data_out", data_out, 8'h3C);

    // Framing error followed by a long break, then recovery
    send(8'h5A, 1'b0, ^8'h5A, BIT_NS);
    drain(50);
    repeat (200) @(negedge clk);
    check("break_data_out", data_out, 8'h3C);
    check("break_busy", busy, 0);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    send_ok(8'h01);
    drain(200);
    check("recover_data_out", data_out, 8'h01);

    // Reset in the middle of bit 4 of 8'hFF
    rx = 1'b0;
    #(BIT_NS);
    rx = 1'b1;
    #(4 * BIT_NS + 53);
    rst = 1'b1;
    #1;
    check("midrst_data_out", data_out, 0);
    check("midrst_data_valid", data_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_frame_err", frame_err, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (100) @(negedge clk);
    check("postrst_data_out", data_out, 0);
    send_ok(8'h81);
    drain(200);
    check("postrst_81", data_out, 8'h81);

    // Transmitter 2% slow, then 2% fast
    send(8'h96, 1'b1, ^8'h96, BIT_NS + BIT_NS / 50);
    @(negedge clk);
    drain(200);
    check("slow_data_out", data_out, 8'h96);
    send(8'h69, 1'b1, ^8'h69, BIT_NS - BIT_NS / 50);
    @(negedge clk);
    drain(200);
    check("fast_data_out", data_out, 8'h69);

`ifdef UART_RX_PARITY_EN
    // Even parity: correct bit, then wrong bit
    send(8'h03, 1'b1, 1'b0, BIT_NS);
    drain(200);
    check("par_ok_data_out", data_out, 8'h03);
    send_ok(8'h81);
    drain(200);
    send(8'h03, 1'b1, 1'b1, BIT_NS);
    drain(200);
    check("par_bad_data_out", data_out, 8'h81);
`endif

    repeat (20) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
